// File: rtl/adc_req_arbiter_if.sv
// Requester and SPI_Driver bundle for adc_req_arbiter.
// slave: arbiter side; master: requesters plus converter.
interface adc_req_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 10
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   ack;
  logic [DATA_W-1:0] rdata;
  logic              rerr;
  logic              busy;
  logic              getV;
  logic              vReady;
  logic [DATA_W-1:0] v;

  modport slave (
    input  req,
    input  vReady,
    input  v,
    output ack,
    output rdata,
    output rerr,
    output busy,
    output getV
  );

  modport master (
    output req,
    output vReady,
    output v,
    input  ack,
    input  rdata,
    input  rerr,
    input  busy,
    input  getV
  );
endinterface

// File: rtl/adc_req_arbiter.sv
// Round-robin share of one SPI_Driver ADC among NREQ requesters.
// Ports: CLK, RST_N (async, active-low), bus (slave modport):
//   req/ack/rdata/rerr/busy to requesters, getV/vReady/v to ADC.
// ADC_AVG_EN: four conversions per grant, result averaged.
module adc_req_arbiter #(
  parameter int NREQ        = 4,
  parameter int DATA_W      = 10,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic             CLK,
  input  logic             RST_N,
  adc_req_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO,
    DONE,
    ABORT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IW-1:0] rr_q;
  logic [IW-1:0] win_q;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [TW-1:0] tmr_q;
  logic          tmo;
  logic          grant;
  logic          cap;
  logic          last_conv;
  logic [DATA_W-1:0] res;

  logic [NREQ-1:0]   ack_q;
  logic [NREQ-1:0]   ack_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              rerr_q;
  logic              rerr_d;
  logic              busy_q;
  logic              busy_d;
  logic              getv_q;
  logic              getv_d;

  assign tmo   = (tmr_q == TMAX);
  assign grant = (state_q == IDLE) && pick_vld;
  assign cap   = (state_q == WAIT_HI) && bus.vReady;

  // Search starts just after the last winner and wraps.
  always_comb begin
    logic [IW:0] s;
    s        = '0;
    pick     = rr_q;
    pick_vld = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      s = {1'b0, rr_q} + (IW+1)'(i);
      if (s >= (IW+1)'(NREQ))
        s = s - (IW+1)'(NREQ);
      if (!pick_vld && bus.req[s[IW-1:0]]) begin
        pick     = s[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

`ifdef ADC_AVG_EN
  localparam int SW = DATA_W + 2;

  logic [SW-1:0] sum_q;
  logic [1:0]    cnt_q;

  assign last_conv = (cnt_q == 2'd3);
  assign res       = sum_q[SW-1:2];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (grant) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      if (cap)
        sum_q <= sum_q + SW'(bus.v);
      if (state_q == WAIT_LO && state_d == WAIT_HI)
        cnt_q <= cnt_q + 2'd1;
    end
  end
`else
  logic [DATA_W-1:0] res_q;

  assign last_conv = 1'b1;
  assign res       = res_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      res_q <= '0;
    else if (cap)
      res_q <= bus.v;
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_q  <= PTR_RST;
      win_q <= '0;
      tmr_q <= '0;
    end else begin
      if (grant) begin
        rr_q  <= pick;
        win_q <= pick;
      end
      // Any state change restarts the timeout window.
      if (state_d != state_q)
        tmr_q <= '0;
      else if (state_q != IDLE)
        tmr_q <= tmr_q + TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ack_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      busy_q  <= 1'b0;
      getv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      busy_q  <= busy_d;
      getv_q  <= getv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld)
          state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // A stale high vReady is taken as the result.
        if (bus.vReady)
          state_d = WAIT_LO;
        else if (tmo)
          state_d = ABORT;
      end
      WAIT_LO: begin
        if (!bus.vReady)
          state_d = last_conv ? DONE : WAIT_HI;
        else if (tmo)
          state_d = ABORT;
      end
      ABORT: begin
        if (!bus.vReady || tmo)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    ack_d   = '0;
    rdata_d = '0;
    rerr_d  = 1'b0;
    getv_d  = (state_d == WAIT_HI);
    busy_d  = (state_d != IDLE);
    if (state_d == DONE) begin
      ack_d  = NREQ'(1) << win_q;
      rerr_d = (state_q == ABORT);
      if (state_q != ABORT)
        rdata_d = res;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.rerr  = rerr_q;
  assign bus.busy  = busy_q;
  assign bus.getV  = getv_q;

endmodule

// File: tb/tb_adc_req_arbiter.sv
// Scoreboard bench for adc_req_arbiter.
// Two instances: long timeout (main) and TIMEOUT_CYC=16 (tmo).
module tb_adc_req_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 10;
`ifdef ADC_AVG_EN
  localparam int NC = 4;
`else
  localparam int NC = 1;
`endif

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [DW-1:0]   rdata;
    logic            rerr;
  } exp_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  adc_req_arbiter_if #(.NREQ(NREQ), .DATA_W(DW)) bus ();
  adc_req_arbiter_if #(.NREQ(NREQ), .DATA_W(DW)) tbus ();

  adc_req_arbiter #(
    .NREQ(NREQ), .DATA_W(DW), .TIMEOUT_CYC(64)
  ) u_dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  adc_req_arbiter #(
    .NREQ(NREQ), .DATA_W(DW), .TIMEOUT_CYC(16)
  ) u_tmo (
    .CLK(CLK), .RST_N(RST_N), .bus(tbus)
  );

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];
  exp_t exp_t_q[$];
  logic [DW-1:0] vq[$];

  int issued[NREQ] = '{default: 0};
  int served[NREQ] = '{default: 0};
  int t_iss = 0;
  int t_srv = 0;
  int dly   = 20;
  int gpulse = 0;
  int tgv    = 0;
  logic gv_prev = 1'b0;
  exp_t me;
  exp_t te;

  // Requesters hold req until each issued request is acked.
  always_comb begin
    bus.req = '0;
    for (int i = 0; i < NREQ; i++)
      bus.req[i] = (issued[i] > served[i]);
  end

  assign tbus.req    = {{(NREQ-1){1'b0}}, (t_iss > t_srv)};
  assign tbus.vReady = 1'b0;
  assign tbus.v      = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ADC model: vReady rises dly cycles into getV, 4-phase.
  initial begin : adc_model
    int cnt;
    cnt = 0;
    bus.vReady = 1'b0;
    bus.v      = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST_N || !bus.getV)
        cnt = 0;
      if (!RST_N) begin
        bus.vReady = 1'b0;
      end else if (bus.getV && !bus.vReady) begin
        cnt++;
        if (cnt >= dly) begin
          bus.v = (vq.size() > 0) ? vq.pop_front() : '0;
          bus.vReady = 1'b1;
          cnt = 0;
        end
      end else if (!bus.getV && bus.vReady) begin
        bus.vReady = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (bus.getV && !gv_prev)
      gpulse++;
    gv_prev = bus.getV;
    if (tbus.getV)
      tgv++;
  end

  always @(negedge CLK) begin
    if (RST_N && bus.ack != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %b expected none", bus.ack);
      end else begin
        me = exp_q.pop_front();
        chk("ack", 32'(bus.ack), 32'(me.ack));
        chk("rdata", 32'(bus.rdata), 32'(me.rdata));
        chk("rerr", 32'(bus.rerr), 32'(me.rerr));
        chk("getv_low_at_ack", 32'(bus.getV), 32'd0);
        chk("busy_at_ack", 32'(bus.busy), 32'd1);
      end
      for (int i = 0; i < NREQ; i++)
        if (bus.ack[i] && issued[i] > served[i])
          served[i]++;
    end
  end

  always @(negedge CLK) begin
    if (RST_N && tbus.ack != '0) begin
      if (exp_t_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tmo_ack: got %b expected none", tbus.ack);
      end else begin
        te = exp_t_q.pop_front();
        chk("tmo_ack", 32'(tbus.ack), 32'(te.ack));
        chk("tmo_rdata", 32'(tbus.rdata), 32'(te.rdata));
        chk("tmo_rerr", 32'(tbus.rerr), 32'(te.rerr));
        chk("tmo_getv_at_ack", 32'(tbus.getV), 32'd0);
      end
      if (t_iss > t_srv)
        t_srv++;
    end
  end

  task automatic push_v(input logic [DW-1:0] val);
    for (int k = 0; k < NC; k++)
      vq.push_back(val);
  endtask

  task automatic exp_push(input logic [NREQ-1:0] a,
                          input logic [DW-1:0] d,
                          input logic e);
    exp_t x;
    x.ack   = a;
    x.rdata = d;
    x.rerr  = e;
    exp_q.push_back(x);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_t_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || exp_t_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %0d/%0d expected 0",
               exp_q.size(), exp_t_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
    @(negedge CLK);
  endtask

  initial begin : stim
    int base;
    exp_t x;

    repeat (3) @(negedge CLK);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_rerr", 32'(bus.rerr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_getv", 32'(bus.getV), 32'd0);
    chk("rst_tmo_busy", 32'(tbus.busy), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // All four requesting; requester 0 twice.
    dly = 3;
    push_v(10'h011);
    push_v(10'h022);
    push_v(10'h033);
    push_v(10'h044);
    push_v(10'h055);
    exp_push(4'b0001, 10'h011, 1'b0);
    exp_push(4'b0010, 10'h022, 1'b0);
    exp_push(4'b0100, 10'h033, 1'b0);
    exp_push(4'b1000, 10'h044, 1'b0);
    exp_push(4'b0001, 10'h055, 1'b0);
    issued[0] += 2;
    issued[1] += 1;
    issued[2] += 1;
    issued[3] += 1;
    drain(2000);

    // Single request, slow converter.
    dly = 20;
    push_v(10'h2A5);
    exp_push(4'b0001, 10'h2A5, 1'b0);
    issued[0] += 1;
    @(negedge CLK);
    chk("t1_getv_latency", 32'(bus.getV), 32'd1);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    drain(600);

    // Requester 1 served, then 1 and 3 together.
    dly = 2;
    push_v(10'h101);
    exp_push(4'b0010, 10'h101, 1'b0);
    issued[1] += 1;
    drain(300);
    push_v(10'h333);
    push_v(10'h111);
    exp_push(4'b1000, 10'h333, 1'b0);
    exp_push(4'b0010, 10'h111, 1'b0);
    issued[1] += 1;
    issued[3] += 1;
    drain(600);

    // Converter never answers.
    base = tgv;
    x.ack   = 4'b0001;
    x.rdata = '0;
    x.rerr  = 1'b1;
    exp_t_q.push_back(x);
    t_iss += 1;
    drain(300);
    chk("t4_busy_after", 32'(tbus.busy), 32'd0);
    chk("t4_getv_cycles", 32'(tgv - base), 32'd16);

    // Reset while waiting for vReady.
    dly = 40;
    issued[0] += 1;
    repeat (5) @(negedge CLK);
    chk("t5_getv_pre", 32'(bus.getV), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("t5_getv_async", 32'(bus.getV), 32'd0);
    chk("t5_busy_async", 32'(bus.busy), 32'd0);
    dly = 3;
    push_v(10'h077);
    push_v(10'h088);
    exp_push(4'b0001, 10'h077, 1'b0);
    exp_push(4'b0010, 10'h088, 1'b0);
    issued[1] += 1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    drain(600);

`ifdef ADC_AVG_EN
    // Four conversions averaged into one ack.
    base = gpulse;
    vq.push_back(10'd100);
    vq.push_back(10'd101);
    vq.push_back(10'd102);
    vq.push_back(10'd104);
    exp_push(4'b0100, 10'd101, 1'b0);
    issued[2] += 1;
    drain(600);
    chk("t6_getv_pulses", 32'(gpulse - base), 32'd4);
`endif

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
